// File: rtl/mario_pkg.sv
// mario_pkg: shared types, default keycodes and helpers for mario_motion.
// Provides motion_state_t, the keycode constants, vel_t and step_toward().
package mario_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_t;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    localparam int VEL_W_DEF = 6;
    typedef logic signed [VEL_W_DEF-1:0] vel_t;

    // Wide signed carrier so the helper serves any velocity width.
    localparam int STEP_W = 16;
    typedef logic signed [STEP_W-1:0] step_t;

    // Move cur one unit toward tgt; hold once they are equal.
    function automatic step_t step_toward(input step_t cur, input step_t tgt);
        step_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + step_t'(1);
        end else if (cur > tgt) begin
            res = cur - step_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/mario_motion_axis_clamp.sv
// axis_clamp: next position along one axis plus low/high bound clamping.
// Ports: pos/vel in, hi_en gates the high bound, pos_next/hit_lo/hit_hi out.
module axis_clamp #(
    parameter int POS_W = 10,
    parameter int VEL_W = 6,
    parameter int SIZE  = 8,
    parameter int LO    = 0,
    parameter int HI    = 639
) (
    input  logic [POS_W-1:0]        pos,
    input  logic signed [VEL_W-1:0] vel,
    input  logic                    hi_en,
    output logic [POS_W-1:0]        pos_next,
    output logic                    hit_lo,
    output logic                    hit_hi
);
    import mario_pkg::*;

    // Two extra bits keep an overshoot past either bound from wrapping.
    localparam int W = POS_W + 2;
    localparam logic signed [W-1:0] LO_LIM = W'(LO + SIZE);
    localparam logic signed [W-1:0] HI_LIM = W'(HI - SIZE);

    logic signed [W-1:0] raw;

    always_comb begin
        raw    = $signed({2'b00, pos}) + W'(vel);
        hit_hi = hi_en && (raw >= HI_LIM);
        hit_lo = !hit_hi && (raw <= LO_LIM);
        if (hit_hi) begin
            pos_next = HI_LIM[POS_W-1:0];
        end else if (hit_lo) begin
            pos_next = LO_LIM[POS_W-1:0];
        end else begin
            pos_next = raw[POS_W-1:0];
        end
    end

endmodule

// File: rtl/mario_motion.sv
// mario_motion: per-frame player kinematics (accel, friction, gravity, jump).
// Ports: frame_clk, Reset (sync, active-high), keycode -> PosX/PosY/VelX/VelY,
// Airborne, Facing_Left, Size. Optional short hop: MARIO_VAR_JUMP_EN.
module mario_motion #(
    parameter int         POS_W     = 10,
    parameter int         VEL_W     = 6,
    parameter int         SIZE      = 8,
    parameter int         X_MIN     = 0,
    parameter int         X_MAX     = 639,
    parameter int         Y_MIN     = 0,
    parameter int         Y_GROUND  = 469,
    parameter int         X_START   = 320,
    parameter int         X_VMAX    = 3,
    parameter int         JUMP_V    = 8,
    parameter int         VY_MAX    = 6,
    parameter int         GRAV_DIV  = 2,
    parameter logic [7:0] KEY_LEFT  = mario_pkg::KEY_LEFT,
    parameter logic [7:0] KEY_RIGHT = mario_pkg::KEY_RIGHT,
    parameter logic [7:0] KEY_JUMP  = mario_pkg::KEY_JUMP
) (
    input  logic             frame_clk,
    input  logic             Reset,
    input  logic [7:0]       keycode,
    output logic [POS_W-1:0] PosX,
    output logic [POS_W-1:0] PosY,
    output logic [VEL_W-1:0] VelX,
    output logic [VEL_W-1:0] VelY,
    output logic             Airborne,
    output logic             Facing_Left,
    output logic [POS_W-1:0] Size
);
    import mario_pkg::*;

    typedef logic signed [VEL_W-1:0] v_t;

    localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GRAV_DIV - 1);
    localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1);

    localparam v_t VX_LIM = v_t'(X_VMAX);
    localparam v_t VY_LIM = v_t'(VY_MAX);
    localparam v_t V_JUMP = v_t'(-JUMP_V);
    localparam v_t V_ONE  = v_t'(1);
`ifdef MARIO_VAR_JUMP_EN
    localparam v_t V_HOP  = v_t'(-2);
`endif

    localparam logic [POS_W-1:0] X_RST = POS_W'(X_START);
    localparam logic [POS_W-1:0] Y_RST = POS_W'(Y_GROUND - SIZE);

    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    v_t               vel_x_q, vel_x_d;
    v_t               vel_y_q, vel_y_d;
    motion_state_t    state_q, state_d;
    logic             face_q, face_d;
    logic [GC_W-1:0]  gcnt_q, gcnt_d;

    v_t               vx_tgt, vx_step, vy_new;
    motion_state_t    st_new;
    logic [GC_W-1:0]  gc_new;

    logic [POS_W-1:0] x_next, y_next;
    logic             x_lo, x_hi, y_lo, y_hi;

    // Velocity and airborne state before any bound is applied.
    always_comb begin
        vx_tgt = '0;
        if (keycode == KEY_LEFT) begin
            vx_tgt = -VX_LIM;
        end else if (keycode == KEY_RIGHT) begin
            vx_tgt = VX_LIM;
        end
        vx_step = v_t'(step_toward(step_t'(vel_x_q), step_t'(vx_tgt)));

        face_d = face_q;
        if (keycode == KEY_LEFT) begin
            face_d = 1'b1;
        end else if (keycode == KEY_RIGHT) begin
            face_d = 1'b0;
        end

        vy_new = vel_y_q;
        st_new = state_q;
        gc_new = gcnt_q;
        if (state_q == GROUNDED) begin
            gc_new = '0;
            if (keycode == KEY_JUMP) begin
                vy_new = V_JUMP;
                st_new = RISING;
            end else begin
                vy_new = '0;
            end
        end else begin
            gc_new = (gcnt_q == GC_LAST) ? '0 : gcnt_q + GC_ONE;
            if (gc_new == '0) begin
                vy_new = (vel_y_q >= VY_LIM) ? VY_LIM : vel_y_q + V_ONE;
            end
`ifdef MARIO_VAR_JUMP_EN
            if (state_q == RISING && keycode != KEY_JUMP && vy_new < V_HOP) begin
                vy_new = V_HOP;
            end
`endif
            if (state_q == RISING && !vy_new[VEL_W-1]) begin
                st_new = FALLING;
            end
        end
    end

    axis_clamp #(
        .POS_W(POS_W), .VEL_W(VEL_W), .SIZE(SIZE), .LO(X_MIN), .HI(X_MAX)
    ) u_clamp_x (
        .pos(pos_x_q), .vel(vx_step), .hi_en(1'b1),
        .pos_next(x_next), .hit_lo(x_lo), .hit_hi(x_hi)
    );

    // The floor only catches a player who was already in the air.
    axis_clamp #(
        .POS_W(POS_W), .VEL_W(VEL_W), .SIZE(SIZE), .LO(Y_MIN), .HI(Y_GROUND)
    ) u_clamp_y (
        .pos(pos_y_q), .vel(vy_new), .hi_en(state_q != GROUNDED),
        .pos_next(y_next), .hit_lo(y_lo), .hit_hi(y_hi)
    );

    always_comb begin
        pos_x_d = x_next;
        vel_x_d = (x_lo || x_hi) ? '0 : vx_step;
        pos_y_d = y_next;
        vel_y_d = vy_new;
        state_d = st_new;
        gcnt_d  = gc_new;
        if (y_hi) begin
            vel_y_d = '0;
            state_d = GROUNDED;
        end else if (y_lo) begin
            vel_y_d = '0;
            state_d = FALLING;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pos_x_q <= X_RST;
            pos_y_q <= Y_RST;
            vel_x_q <= '0;
            vel_y_q <= '0;
            state_q <= GROUNDED;
            face_q  <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            state_q <= state_d;
            face_q  <= face_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign PosX        = pos_x_q;
    assign PosY        = pos_y_q;
    assign VelX        = vel_x_q;
    assign VelY        = vel_y_q;
    assign Airborne    = (state_q != GROUNDED);
    assign Facing_Left = face_q;
    assign Size        = POS_W'(SIZE);

endmodule

// File: tb/tb_mario_motion.sv
// tb_mario_motion: vector table, hand sequences and random run vs a model.
// Honours MARIO_VAR_JUMP_EN in its expectations.
module tb_mario_motion;

    localparam logic [7:0] KL = 8'h04;
    localparam logic [7:0] KR = 8'h07;
    localparam logic [7:0] KJ = 8'h1A;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic [9:0] PosX, PosY, Size;
    logic [5:0] VelX, VelY;
    logic       Airborne, Facing_Left;

    mario_motion dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .PosX(PosX), .PosY(PosY), .VelX(VelX), .VelY(VelY),
        .Airborne(Airborne), .Facing_Left(Facing_Left), .Size(Size)
    );

    always #5 frame_clk = ~frame_clk;

    int n_pass = 0;
    int n_total = 0;
    int n_print = 0;

    // Reference model state in plain integers.
    int m_x, m_y, m_vx, m_vy, m_gc;
    bit m_air, m_rise, m_face;

    function automatic int sx(input logic [5:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_step(input bit rst, input logic [7:0] k);
        int tgt, nx, ny;
        bit was_air;
        if (rst) begin
            m_x = 320; m_y = 461; m_vx = 0; m_vy = 0; m_gc = 0;
            m_air = 0; m_rise = 0; m_face = 0;
            return;
        end
        tgt = (k == KL) ? -3 : (k == KR) ? 3 : 0;
        if (m_vx < tgt) m_vx++;
        else if (m_vx > tgt) m_vx--;
        if (k == KL) m_face = 1;
        if (k == KR) m_face = 0;
        was_air = m_air;
        if (!m_air) begin
            if (k == KJ) begin
                m_vy = -8; m_air = 1; m_rise = 1; m_gc = 0;
            end else begin
                m_vy = 0;
            end
        end else begin
            m_gc = (m_gc + 1) % 2;
            if (m_gc == 0) m_vy = (m_vy + 1 > 6) ? 6 : m_vy + 1;
`ifdef MARIO_VAR_JUMP_EN
            if (m_rise && k != KJ && m_vy < -2) m_vy = -2;
`endif
            if (m_rise && m_vy >= 0) m_rise = 0;
        end
        nx = m_x + m_vx;
        if (nx - 8 <= 0) begin
            m_x = 8; m_vx = 0;
        end else if (nx + 8 >= 639) begin
            m_x = 631; m_vx = 0;
        end else begin
            m_x = nx;
        end
        ny = m_y + m_vy;
        if (was_air && ny + 8 >= 469) begin
            m_y = 461; m_vy = 0; m_air = 0; m_rise = 0;
        end else if (ny - 8 <= 0) begin
            m_y = 8; m_vy = 0; m_air = 1; m_rise = 0;
        end else begin
            m_y = ny;
        end
    endtask

    task automatic frame(input bit rst, input logic [7:0] k);
        Reset = rst;
        keycode = k;
        @(posedge frame_clk);
        #1;
        model_step(rst, k);
    endtask

    task automatic check_model(input int idx);
        n_total++;
        if (int'(PosX) == m_x && int'(PosY) == m_y && sx(VelX) == m_vx &&
            sx(VelY) == m_vy && Airborne == m_air && Facing_Left == m_face) begin
            n_pass++;
        end else if (n_print < 20) begin
            n_print++;
            $display("FAIL rand[%0d]: got x=%0d y=%0d vx=%0d vy=%0d air=%0b f=%0b, expected x=%0d y=%0d vx=%0d vy=%0d air=%0b f=%0b",
                     idx, PosX, PosY, sx(VelX), sx(VelY), Airborne, Facing_Left,
                     m_x, m_y, m_vx, m_vy, m_air, m_face);
        end
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] key;
        int         x, y, vx, vy;
        bit         air, face;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int f;
        logic [7:0] k;
        int hold;

        tbl.push_back(vec_t'{1'b1, 8'h00, 320, 461,  0, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, 8'h00, 320, 461,  0, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KR,    321, 461,  1, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KR,    323, 461,  2, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KR,    326, 461,  3, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KR,    329, 461,  3, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KR,    332, 461,  3, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'h00, 334, 461,  2, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'h00, 335, 461,  1, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, 8'h00, 335, 461,  0, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b0, KL,    334, 461, -1, 0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b0, 8'h00, 334, 461,  0, 0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b0, KR,    335, 461,  1, 0, 1'b0, 1'b0});
        tbl.push_back(vec_t'{1'b1, KR,    320, 461,  0, 0, 1'b0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            frame(tbl[i].rst, tbl[i].key);
            check($sformatf("tbl%0d.x", i), int'(PosX), tbl[i].x);
            check($sformatf("tbl%0d.y", i), int'(PosY), tbl[i].y);
            check($sformatf("tbl%0d.vx", i), sx(VelX), tbl[i].vx);
            check($sformatf("tbl%0d.vy", i), sx(VelY), tbl[i].vy);
            check($sformatf("tbl%0d.air", i), int'(Airborne), int'(tbl[i].air));
            check($sformatf("tbl%0d.face", i), int'(Facing_Left), int'(tbl[i].face));
        end
        check("size", int'(Size), 8);

        // Single jump, key released after takeoff.
        frame(1'b1, 8'h00);
        frame(1'b0, KJ);
        check("jump1.vy", sx(VelY), -8);
        check("jump1.y", int'(PosY), 453);
        check("jump1.air", int'(Airborne), 1);
        frame(1'b0, 8'h00);
`ifdef MARIO_VAR_JUMP_EN
        check("jump2.vy", sx(VelY), -2);
        check("jump2.y", int'(PosY), 451);
`else
        check("jump2.vy", sx(VelY), -8);
        check("jump2.y", int'(PosY), 445);
`endif
        f = 2;
        while (Airborne && f < 80) begin
            frame(1'b0, 8'h00);
            f++;
        end
        check("land.air", int'(Airborne), 0);
        check("land.y", int'(PosY), 461);
        check("land.vy", sx(VelY), 0);
`ifndef MARIO_VAR_JUMP_EN
        check("land.frame", f, 35);
`endif

        // Jump held: land on frame 35, take off again on frame 36.
        frame(1'b1, 8'h00);
        for (int i = 1; i <= 35; i++) frame(1'b0, KJ);
        check("held.land.air", int'(Airborne), 0);
        check("held.land.y", int'(PosY), 461);
        check("held.land.vy", sx(VelY), 0);
        frame(1'b0, KJ);
        check("held.rejump.air", int'(Airborne), 1);
        check("held.rejump.vy", sx(VelY), -8);
        check("held.rejump.y", int'(PosY), 453);

        // Reset while rising at VelY = -5.
        frame(1'b1, 8'h00);
        for (int i = 1; i <= 7; i++) frame(1'b0, KJ);
        check("mid.vy", sx(VelY), -5);
        check("mid.y", int'(PosY), 414);
        frame(1'b1, KJ);
        check("mid.rst.x", int'(PosX), 320);
        check("mid.rst.y", int'(PosY), 461);
        check("mid.rst.vy", sx(VelY), 0);
        check("mid.rst.air", int'(Airborne), 0);

        // Left wall.
        f = 0;
        while (PosX != 10'd8 && f < 200) begin
            frame(1'b0, KL);
            f++;
        end
        check("lwall.x", int'(PosX), 8);
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, KL);
            check("lwall.hold.x", int'(PosX), 8);
            check("lwall.hold.vx", sx(VelX), 0);
        end

        // Right wall.
        f = 0;
        while (PosX != 10'd631 && f < 300) begin
            frame(1'b0, KR);
            f++;
        end
        check("rwall.x", int'(PosX), 631);
        frame(1'b0, KR);
        check("rwall.hold.x", int'(PosX), 631);
        check("rwall.hold.vx", sx(VelX), 0);
        check("rwall.face", int'(Facing_Left), 0);

        // Random held keys against the model.
        frame(1'b1, 8'h00);
        f = 0;
        while (f < 2500) begin
            case ($urandom_range(0, 9))
                0, 1, 2: k = KL;
                3, 4, 5: k = KR;
                6, 7:    k = KJ;
                8:       k = 8'h00;
                default: k = 8'($urandom);
            endcase
            hold = $urandom_range(1, 24);
            for (int j = 0; j < hold; j++) begin
                frame($urandom_range(0, 199) == 0, k);
                check_model(f);
                f++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
